// File: rtl/edge_trigger.sv
// ---------------------------------------------------------------------------
// edge_trigger
//   Front end of the acquisition path. Synchronises an asynchronous trigger
//   source, detects the selected edge, and fires a fixed-width registered
//   pulse. After each pulse an optional hold-off window ignores further
//   edges. Edges seen while the pulse or hold-off is active are dropped; they
//   do not extend the pulse and are not queued.
//
//   Optional feature macro: EDGE_TRIGGER_GLITCH_FILTER_EN
//     When defined, the synchronised level only changes after the new value
//     has been stable for FILTER_LEN consecutive cycles. This adds FILTER_LEN
//     cycles of latency. When undefined, the filter is absent and FILTER_LEN
//     has no effect.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on signal_in (1..4)
//   EDGE_MODE    0 = rising, 1 = falling, 2 = both
//   PULSE_WIDTH  pulse_out high time in clk cycles (1..255)
//   HOLDOFF      dead cycles after a pulse ends (0..255)
//   FILTER_LEN   glitch-filter stability count (1..15, filter builds only)
//
// Ports
//   clk        in   system clock; all logic runs on its rising edge
//   reset      in   synchronous, active-high reset
//   signal_in  in   asynchronous trigger source
//   pulse_out  out  registered trigger pulse
// ---------------------------------------------------------------------------
module edge_trigger #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int PULSE_WIDTH = 1,
    parameter int HOLDOFF     = 0,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic signal_in,
    output logic pulse_out
);

`ifdef EDGE_TRIGGER_GLITCH_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // Arming must outlast the time the reset-time input level needs to reach
    // the edge detector, otherwise that level would look like a fresh edge.
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + (FILTER_EN ? FILTER_LEN : 0);
    localparam int ARM_W      = $clog2(ARM_CYCLES);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

    localparam logic [7:0] WIDTH_LOAD = 8'(PULSE_WIDTH - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // ---------------- synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    assign sync_d[0] = signal_in;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Level seen by the edge detector (filtered or raw synchronised level).
    logic det_lvl;

`ifdef EDGE_TRIGGER_GLITCH_FILTER_EN
    logic       flt_lvl_q;
    logic       flt_lvl_d;
    logic [3:0] flt_cnt_q;
    logic [3:0] flt_cnt_d;

    // Count consecutive samples that disagree with the current filtered
    // level; any agreeing sample restarts the count.
    always_comb begin
        flt_lvl_d = flt_lvl_q;
        flt_cnt_d = '0;
        if (sync_q[SYNC_STAGES-1] != flt_lvl_q) begin
            if (flt_cnt_q == 4'(FILTER_LEN - 1)) begin
                flt_lvl_d = sync_q[SYNC_STAGES-1];
            end else begin
                flt_cnt_d = flt_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flt_lvl_q <= 1'b0;
            flt_cnt_q <= '0;
        end else begin
            flt_lvl_q <= flt_lvl_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign det_lvl = flt_lvl_q;
`else
    assign det_lvl = sync_q[SYNC_STAGES-1];
`endif

    // ---------------- edge detect and arming ----------------
    logic             prev_q;
    logic [ARM_W-1:0] arm_cnt_q;
    logic [ARM_W-1:0] arm_cnt_d;
    logic             armed_q;
    logic             armed_d;
    logic             rise;
    logic             fall;
    logic             edge_sel;
    logic             edge_hit;

    assign rise = det_lvl & ~prev_q;
    assign fall = ~det_lvl & prev_q;

    always_comb begin
        if (EDGE_MODE == 0) begin
            edge_sel = rise;
        end else if (EDGE_MODE == 1) begin
            edge_sel = fall;
        end else begin
            edge_sel = rise | fall;
        end
    end

    assign edge_hit = armed_q & edge_sel;

    always_comb begin
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (!armed_q) begin
            if (arm_cnt_q == ARM_LAST) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + ARM_W'(1);
            end
        end
    end

    // ---------------- pulse / hold-off FSM ----------------
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       pulse_q;
    logic       pulse_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_hit) begin
                    state_d = ST_PULSE;
                    cnt_d   = WIDTH_LOAD;
                    pulse_d = 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 8'd0) begin
                    pulse_d = 1'b0;
                    if (HOLDOFF > 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pulse_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= 1'b0;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
        end else begin
            prev_q    <= det_lvl;
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: tb/tb_edge_trigger.sv
// ---------------------------------------------------------------------------
// tb_edge_trigger
//   Five edge_trigger instances with different configurations share one
//   stimulus stream. A per-cycle vector table holds the inputs and the
//   expected pulse_out of every instance; expected values are queued when a
//   row is driven and compared at the following falling clock edge.
//   Instance map: 0 def (rise, w1, h0), 1 w4h3 (rise, w4, h3),
//   2 both (both edges, w1), 3 fall (falling, w1), 4 w4 (rise, w4, h0).
// ---------------------------------------------------------------------------
module tb_edge_trigger;
    localparam int N_DUT  = 5;
    localparam int N_ROWS = 110;

    typedef struct {
        logic             rst;
        logic             sig;
        logic [N_DUT-1:0] exp;
    } vec_t;

    vec_t             vecs [N_ROWS];
    logic [N_DUT-1:0] exp_q [$];
    string            names [N_DUT] = '{"def", "w4h3", "both", "fall", "w4"};

    logic             clk = 1'b0;
    logic             reset;
    logic             signal_in;
    logic [N_DUT-1:0] pulse;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    edge_trigger #(.SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_WIDTH(1), .HOLDOFF(0)) u_def (
        .clk(clk), .reset(reset), .signal_in(signal_in), .pulse_out(pulse[0]));
    edge_trigger #(.SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_WIDTH(4), .HOLDOFF(3)) u_w4h3 (
        .clk(clk), .reset(reset), .signal_in(signal_in), .pulse_out(pulse[1]));
    edge_trigger #(.SYNC_STAGES(2), .EDGE_MODE(2), .PULSE_WIDTH(1), .HOLDOFF(0)) u_both (
        .clk(clk), .reset(reset), .signal_in(signal_in), .pulse_out(pulse[2]));
    edge_trigger #(.SYNC_STAGES(2), .EDGE_MODE(1), .PULSE_WIDTH(1), .HOLDOFF(0)) u_fall (
        .clk(clk), .reset(reset), .signal_in(signal_in), .pulse_out(pulse[3]));
    edge_trigger #(.SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_WIDTH(4), .HOLDOFF(0)) u_w4 (
        .clk(clk), .reset(reset), .signal_in(signal_in), .pulse_out(pulse[4]));

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic void set_sig(input int from, input int to);
        for (int i = from; i <= to; i++) vecs[i].sig = 1'b1;
    endfunction

    function automatic void mark(input int d, input int start, input int width);
        for (int i = start; i < start + width; i++) vecs[i].exp[d] = 1'b1;
    endfunction

    task automatic compare_row(input int r);
        logic [N_DUT-1:0] e;
        e = exp_q.pop_front();
        $display("row %0d rst=%b sig=%b pulse=%b exp=%b", r, vecs[r].rst, vecs[r].sig, pulse, e);
        for (int d = 0; d < N_DUT; d++) begin
            check($sformatf("row%0d_%s", r, names[d]), int'(pulse[d]), int'(e[d]));
        end
    endtask

    initial begin
        int n;
        int w;
        int d1;
        bit found;

        reset     = 1'b1;
        signal_in = 1'b0;

        // ---- build vector table (row i = inputs before edge i, pulse after edge i)
        for (int i = 0; i < N_ROWS; i++) begin
            vecs[i].rst = 1'b0;
            vecs[i].sig = 1'b0;
            vecs[i].exp = '0;
        end
        vecs[0].rst  = 1'b1;
        vecs[1].rst  = 1'b1;
        vecs[83].rst = 1'b1;    // reset lands in the middle of the w4 pulses
        vecs[84].rst = 1'b1;

        set_sig(0, 11);         // high through reset: arming must suppress
        set_sig(22, 26);        // 0->1 held 5 cycles
        set_sig(37, 37);        // 1-high, 1-low, 1-high
        set_sig(39, 39);
        set_sig(50, 51);        // rises 5 cycles apart (second one in hold-off)
        set_sig(55, 56);
        set_sig(65, 68);        // 0->1->0 spaced 4 cycles
        set_sig(80, 99);        // rise, then reset mid-pulse with input held high

        // def: rise-only, 1 cycle, latency 2
        mark(0, 24, 1); mark(0, 39, 1); mark(0, 41, 1); mark(0, 52, 1);
        mark(0, 57, 1); mark(0, 67, 1); mark(0, 82, 1);
        // w4h3: 4 wide, second rise during hold-off ignored, aborted by reset
        mark(1, 24, 4); mark(1, 39, 4); mark(1, 52, 4); mark(1, 67, 4); mark(1, 82, 1);
        // both edges
        mark(2, 14, 1); mark(2, 24, 1); mark(2, 29, 1); mark(2, 39, 1); mark(2, 41, 1);
        mark(2, 52, 1); mark(2, 54, 1); mark(2, 57, 1); mark(2, 59, 1); mark(2, 67, 1);
        mark(2, 71, 1); mark(2, 82, 1); mark(2, 102, 1);
        // falling only
        mark(3, 14, 1); mark(3, 29, 1); mark(3, 40, 1); mark(3, 42, 1); mark(3, 54, 1);
        mark(3, 59, 1); mark(3, 71, 1); mark(3, 102, 1);
        // w4 without hold-off: second rise accepted right after the pulse
        mark(4, 24, 4); mark(4, 39, 4); mark(4, 52, 4); mark(4, 57, 4); mark(4, 67, 4);
        mark(4, 82, 1);

        // ---- apply table, scoreboard compares one row behind
        for (int i = 0; i < N_ROWS; i++) begin
            @(negedge clk);
            if (i > 0) compare_row(i - 1);
            reset     = vecs[i].rst;
            signal_in = vecs[i].sig;
            exp_q.push_back(vecs[i].exp);
        end
        @(negedge clk);
        compare_row(N_ROWS - 1);

        // ---- hand sequence: latency and width measured directly
        signal_in = 1'b1;
        n     = 0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            n++;
            if (pulse[0]) found = 1'b1;
        end
        check("latency_def", found ? n : -1, 3);

        w  = 0;
        d1 = 0;
        for (int k = 0; k < 20; k++) begin
            if (!pulse[4]) break;
            w++;
            if (pulse[0]) d1++;
            @(negedge clk);
        end
        check("width_w4", w, 4);
        check("width_def", d1, 1);
        $display("hand seq latency=%0d w4_width=%0d def_width=%0d", n, w, d1);

        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
